audio_sample_fifo: RTL and testbench

AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

---
 rtl/audio_pkg.sv | 15 +
 rtl/audio_sample_fifo_if.sv | 30 +++
 rtl/sample_fifo_mem.sv | 29 ++
 rtl/audio_sample_fifo.sv | 134 +++++++++++++
 tb/tb_audio_sample_fifo.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared defaults and controller state type for the audio sample FIFO
// No ports: parameter defaults (sample width, clock and output rates) and state_t.
package audio_pkg;

  localparam int DEF_SAMPLE_BITS = 16;
  localparam int DEF_CLK_FREQ_HZ = 100_000_000;
  localparam int DEF_OUT_RATE_HZ = 48_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/audio_sample_fifo_if.sv
// rtl/audio_sample_fifo_if.sv - sample stream bundle between decoder, FIFO and modulator
// in_sample/in_valid : decoder -> FIFO, one-cycle strobe per sample
// out_sample/out_valid : FIFO -> modulator, one-cycle strobe per output tick
// modport slave is the FIFO side, modport master the driving/observing side.
interface audio_sample_fifo_if
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS
);

  logic signed [SAMPLE_BITS-1:0] in_sample;
  logic                          in_valid;
  logic signed [SAMPLE_BITS-1:0] out_sample;
  logic                          out_valid;

  modport master (
    output in_sample,
    output in_valid,
    input  out_sample,
    input  out_valid
  );

  modport slave (
    input  in_sample,
    input  in_valid,
    output out_sample,
    output out_valid
  );

endinterface

// File: rtl/sample_fifo_mem.sv
// rtl/sample_fifo_mem.sv - sample storage array, synchronous write, combinational read
// clk   : system clock
// we    : write strobe, stores wdata at waddr on the rising edge
// raddr : read address, rdata follows it combinationally
module sample_fifo_mem
  import audio_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = DEF_SAMPLE_BITS
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic signed [WIDTH-1:0]  wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic signed [WIDTH-1:0]  rdata
);

  logic signed [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - rate-decoupling FIFO from PWM decoder to FM modulator
// clk, rst      : system clock, synchronous active-high reset
// enable        : low flushes the FIFO and idles the controller
// clear_flags   : clears overflow/underflow (a same-cycle set wins)
// bus (slave)   : in_sample/in_valid in, registered out_sample/out_valid out
// fifo_level    : exact occupancy 0..FIFO_DEPTH
// overflow      : sticky, an input sample was dropped
// underflow     : sticky, the FIFO was empty at an output tick while running
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int OUT_RATE_HZ = DEF_OUT_RATE_HZ,
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        clear_flags,
  audio_sample_fifo_if.slave          bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int DIV   = CLK_FREQ_HZ / OUT_RATE_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_HALF = LVL_W'(FIFO_DEPTH / 2);

  state_t                        state;
  state_t                        state_next;
  logic [CNT_W-1:0]              rate_cnt;
  logic [PTR_W-1:0]              wr_ptr;
  logic [PTR_W-1:0]              rd_ptr;
  logic signed [SAMPLE_BITS-1:0] head;
  logic                          tick;
  logic                          fifo_empty;
  logic                          fifo_full;
  logic                          do_pop;
  logic                          do_push;
  logic                          set_ovf;
  logic                          set_udf;

  sample_fifo_mem #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata (bus.in_sample),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    fifo_empty = (fifo_level == '0);
    fifo_full  = (fifo_level == LVL_FULL);
    tick       = enable && (rate_cnt == CNT_LAST);
    // Empty test uses the pre-edge level, so a write landing with the tick
    // is stored and the tick still counts as an underflow.
    do_pop     = (state == ST_RUN) && tick && !fifo_empty;
    set_udf    = (state == ST_RUN) && tick && fifo_empty;
    // A pop in the same cycle frees the slot the write needs.
    do_push    = enable && bus.in_valid && (!fifo_full || do_pop);
    set_ovf    = enable && bus.in_valid && fifo_full && !do_pop;

    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_PRIME;
        ST_PRIME: if (fifo_level >= LVL_HALF) state_next = ST_RUN;
        ST_RUN:   if (set_udf) state_next = ST_PRIME;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_cnt       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      bus.out_sample <= '0;
      bus.out_valid  <= 1'b0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      if (!enable || tick) begin
        rate_cnt <= '0;
      end else begin
        rate_cnt <= rate_cnt + CNT_W'(1);
      end

      if (!enable) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        fifo_level <= fifo_level + LVL_W'(do_push) - LVL_W'(do_pop);
      end

      // The modulator sees a strobe on every tick once primed or running;
      // without a pop it simply re-uses the held sample.
      bus.out_valid <= tick && (state != ST_IDLE);
      if (do_pop) begin
        bus.out_sample <= head;
      end

      overflow  <= set_ovf | (overflow & ~clear_flags);
      underflow <= set_udf | (underflow & ~clear_flags);
    end
  end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb/tb_audio_sample_fifo.sv - self-checking bench for audio_sample_fifo
module tb_audio_sample_fifo;

  localparam int CLK_HZ  = 1000;
  localparam int RATE_HZ = 100;
  localparam int DIV     = CLK_HZ / RATE_HZ;
  localparam int DEPTH   = 8;
  localparam int SB      = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       clear_flags;
  logic [3:0] fifo_level;
  logic       overflow;
  logic       underflow;

  audio_sample_fifo_if #(.SAMPLE_BITS(SB)) bus ();

  audio_sample_fifo #(
    .CLK_FREQ_HZ (CLK_HZ),
    .OUT_RATE_HZ (RATE_HZ),
    .SAMPLE_BITS (SB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .clear_flags (clear_flags),
    .bus         (bus),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_PRIME, M_RUN} mode_t;

  logic signed [SB-1:0] mq[$];
  logic signed [SB-1:0] got[$];
  mode_t                mode = M_IDLE;
  int                   phase = 0;
  logic signed [SB-1:0] m_out = '0;
  bit                   m_valid = 1'b0;
  bit                   m_ovf = 1'b0;
  bit                   m_udf = 1'b0;
  int                   checks = 0;
  int                   errors = 0;

  task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Queue-based reference: one call per rising edge, using the inputs held
  // across that edge.
  task automatic model_edge();
    int lvl;
    bit tick, pop, und_ev, ovf_ev;
    if (rst) begin
      mq.delete();
      mode = M_IDLE; phase = 0; m_out = '0;
      m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      return;
    end
    lvl     = mq.size();
    tick    = enable && (phase == DIV - 1);
    m_valid = tick && (mode != M_IDLE);
    pop     = (mode == M_RUN) && tick && (lvl > 0);
    und_ev  = (mode == M_RUN) && tick && (lvl == 0);
    ovf_ev  = enable && bus.in_valid && (lvl == DEPTH) && !pop;
    if (pop) m_out = mq.pop_front();
    if (enable && bus.in_valid && !ovf_ev) mq.push_back(bus.in_sample);
    if (!enable) mq.delete();
    m_udf = und_ev ? 1'b1 : (clear_flags ? 1'b0 : m_udf);
    m_ovf = ovf_ev ? 1'b1 : (clear_flags ? 1'b0 : m_ovf);
    phase = enable ? (phase + 1) % DIV : 0;
    if (!enable) mode = M_IDLE;
    else if (mode == M_IDLE) mode = M_PRIME;
    else if (mode == M_PRIME && lvl >= DEPTH / 2) mode = M_RUN;
    else if (mode == M_RUN && und_ev) mode = M_PRIME;
  endtask

  task automatic step(bit en, bit iv, logic signed [SB-1:0] s, bit clr, bit r);
    rst = r; enable = en; bus.in_valid = iv; bus.in_sample = s; clear_flags = clr;
    @(posedge clk);
    model_edge();
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_sample", 32'(bus.out_sample), 32'(m_out));
    check("fifo_level", 32'(fifo_level), mq.size());
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_udf));
    if (bus.out_valid === 1'b1) got.push_back(bus.out_sample);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic signed [SB-1:0] e034[4];
    logic signed [SB-1:0] s9[9];
    logic signed [SB-1:0] e039[4];
    logic signed [SB-1:0] smp;
    int pct;
    bit en_r, iv_r, clr_r, rst_r;
    e034 = '{16'sd100, 16'sd200, 16'sd300, 16'sd400};
    e039 = '{16'sd11, 16'sd22, -16'sd33, 16'sd44};
    for (int i = 0; i < 9; i++) s9[i] = SB'(-500 + i * 111);

    // Reset values
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("rst_out_sample", 32'(bus.out_sample), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_flags", 32'({overflow, underflow}), 0);

    // Prime with four samples, then play them out on ticks 10/20/30/40
    got.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, e034[i], 1'b0, 1'b0);
    idle(38);
    check("r034_count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      check("r034_sample", (i < got.size()) ? 32'(got[i]) : 'x, 32'(e034[i]));

    // Empty at the next tick: strobe, held sample, underflow, back to priming
    idle(8);
    check("r036_valid", 32'(bus.out_valid), 1);
    check("r036_hold", 32'(bus.out_sample), 400);
    check("r036_underflow", 32'(underflow), 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, SB'(7 + i), 1'b0, 1'b0);
    idle(27);
    check("r036_no_pop_level", 32'(fifo_level), 3);
    check("r036_no_pop_hold", 32'(bus.out_sample), 400);

    // Enable low for three cycles: flush, no strobes, sample and flags held
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      check("r038_no_valid", 32'(bus.out_valid), 0);
      check("r038_level", 32'(fifo_level), 0);
    end
    check("r038_hold", 32'(bus.out_sample), 400);
    check("r038_udf_kept", 32'(underflow), 1);

    // Nine back-to-back writes before the first post-enable tick
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, s9[i], 1'b0, 1'b0);
      check("r038_no_early_tick", 32'(bus.out_valid), 0);
    end
    check("r035_level", 32'(fifo_level), 8);
    check("r035_overflow", 32'(overflow), 1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("r038_first_tick", 32'(bus.out_valid), 1);
    check("r034_pop_head", 32'(bus.out_sample), 32'(s9[0]));
    step(1'b1, 1'b1, 16'sd77, 1'b1, 1'b0);
    check("r035_clear_ovf", 32'(overflow), 0);
    check("r035_clear_udf", 32'(underflow), 0);
    check("r035_refill", 32'(fifo_level), 8);

    // Full FIFO with a write coincident with a running tick
    idle(8);
    step(1'b1, 1'b1, 16'sd88, 1'b0, 1'b0);
    check("r037_level", 32'(fifo_level), 8);
    check("r037_no_ovf", 32'(overflow), 0);
    check("r037_pop", 32'(bus.out_sample), 32'(s9[1]));

    // Reset mid-stream at level 5, overriding enable and in_valid
    idle(30);
    check("r039_pre_level", 32'(fifo_level), 5);
    step(1'b1, 1'b1, 16'sd555, 1'b0, 1'b1);
    check("r039_level", 32'(fifo_level), 0);
    check("r039_out_sample", 32'(bus.out_sample), 0);
    check("r039_out_valid", 32'(bus.out_valid), 0);
    got.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, e039[i], 1'b0, 1'b0);
    idle(38);
    check("r039_count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      check("r039_order", (i < got.size()) ? 32'(got[i]) : 'x, 32'(e039[i]));

    // Random traffic against the reference model, input rate varied per segment
    for (int seg = 0; seg < 10; seg++) begin
      pct = (seg % 3 == 0) ? 4 : ((seg % 3 == 1) ? 12 : 30);
      for (int i = 0; i < 300; i++) begin
        rst_r = ($urandom_range(0, 999) == 0);
        en_r  = ($urandom_range(0, 99) < 97);
        iv_r  = ($urandom_range(0, 99) < pct);
        clr_r = ($urandom_range(0, 99) < 2);
        smp   = SB'($urandom);
        step(en_r, iv_r, smp, clr_r, rst_r);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
